// File: rtl/rv_hs_pkg.sv
// Shared ready/valid handshake definitions: default payload width, pointer sizing and
// buffer-depth legality, reused by the ready/valid master/slave blocks.
package rv_hs_pkg;

  localparam int unsigned RV_DATA_W_DEF = 8;
  localparam int unsigned RV_DEPTH_MIN  = 2;

  function automatic int unsigned rv_ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Pointers wrap by natural overflow, so depth must be an exact power of two.
  function automatic bit rv_depth_ok(input int unsigned depth);
    return (depth >= RV_DEPTH_MIN) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port, cleared by reset.
module rv_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              aclk,
  input  logic              rstn,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_rx_fifo.sv
// Ready/valid receive endpoint with a first-word-fall-through buffer of DEPTH words.
// Optional accepted-transfer counter and rx_count port enabled by `define RV_RX_COUNT_EN.
module rv_rx_fifo
  import rv_hs_pkg::*;
#(
  parameter int unsigned DATA_W = RV_DATA_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   aclk,
  input  logic                   rstn,
  input  logic                   m_valid,
  input  logic [DATA_W-1:0]      m_data,
  output logic                   s_ready,
  output logic                   o_valid,
  output logic [DATA_W-1:0]      o_data,
  input  logic                   o_ready,
  output logic [$clog2(DEPTH):0] level
`ifdef RV_RX_COUNT_EN
  ,
  output logic [CNT_W-1:0]       rx_count
`endif
);

  localparam int unsigned PTR_W = rv_ptr_w(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  if (!rv_depth_ok(DEPTH)) begin : g_depth_chk
    $error("rv_rx_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (CNT_W == 0) begin : g_cnt_chk
    $error("rv_rx_fifo: CNT_W must be >= 1");
  end

  logic             rstn_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Ready comes only from registered state, so a pop on a full cycle cannot admit a push.
  assign s_ready = rstn_q && (level != FULL_LVL);
  assign o_valid = (level != '0);
  assign push    = m_valid && s_ready;
  assign pop     = o_valid && o_ready;

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      rstn_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      rstn_q <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

`ifdef RV_RX_COUNT_EN
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      rx_count <= '0;
    end else if (push) begin
      rx_count <= rx_count + 1'b1;
    end
  end
`endif

  rv_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .aclk  (aclk),
    .rstn  (rstn),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (m_data),
    .raddr (rd_ptr),
    .rdata (o_data)
  );

endmodule

// File: tb/tb_rv_rx_fifo.sv
// Self-checking bench for rv_rx_fifo against a queue-based reference model.
// Exercises rx_count when built with `define RV_RX_COUNT_EN.
module tb_rv_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic          aclk = 1'b0;
  logic          rstn = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          o_ready = 1'b0;
  logic          s_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [2:0]    level;
`ifdef RV_RX_COUNT_EN
  logic [CW-1:0] rx_count;
`endif

  rv_rx_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .aclk    (aclk),
    .rstn    (rstn),
    .m_valid (m_valid),
    .m_data  (m_data),
    .s_ready (s_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .level   (level)
`ifdef RV_RX_COUNT_EN
    ,
    .rx_count (rx_count)
`endif
  );

  always #5 aclk = ~aclk;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  logic [DW-1:0] q[$];
  logic          exp_ready = 1'b0;
  int unsigned   exp_cnt = 0;
  bit            last_push = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, " s_ready"}, 32'(s_ready), 32'(exp_ready));
    chk({ph, " o_valid"}, 32'(o_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({ph, " o_data"}, 32'(o_data), 32'(q[0]));
    chk({ph, " level"}, 32'(level), 32'(q.size()));
`ifdef RV_RX_COUNT_EN
    chk({ph, " rx_count"}, 32'(rx_count), exp_cnt % (1 << CW));
`endif
  endtask

  // Called at a falling edge; drives one cycle, advances the model, checks at the next falling edge.
  task automatic cycle(input logic mv, input logic [DW-1:0] md, input logic ordy);
    bit pu, po;
    m_valid = mv;
    m_data  = md;
    o_ready = ordy;
    pu = mv && exp_ready;
    po = (q.size() != 0) && ordy;
    @(posedge aclk);
    if (po) void'(q.pop_front());
    if (pu) begin
      q.push_back(md);
      exp_cnt++;
    end
    exp_ready = (q.size() != DEPTH);
    last_push = pu;
    @(negedge aclk);
    check_outputs("cyc");
  endtask

  task automatic apply_reset();
    #2;
    rstn    = 1'b0;
    m_valid = 1'b0;
    o_ready = 1'b0;
    #1;
    q.delete();
    exp_ready = 1'b0;
    exp_cnt   = 0;
    chk("rst o_valid", 32'(o_valid), 32'd0);
    chk("rst level",   32'(level),   32'd0);
    chk("rst s_ready", 32'(s_ready), 32'd0);
    chk("rst o_data",  32'(o_data),  32'd0);
`ifdef RV_RX_COUNT_EN
    chk("rst rx_count", 32'(rx_count), 32'd0);
`endif
    @(negedge aclk);
    @(negedge aclk);
    rstn = 1'b1;
    check_outputs("rel");
  endtask

  initial begin
    bit            pend;
    logic [DW-1:0] w;

    // Reset release: ready rises one edge later
    @(negedge aclk);
    apply_reset();
    cycle(1'b0, 8'h00, 1'b0);
    chk("ready_after_release", 32'(s_ready), 32'd1);

    // Streaming with consumer always ready
    cycle(1'b1, 8'h11, 1'b1);
    chk("stream first out", 32'(o_data), 32'h11);
    cycle(1'b1, 8'h22, 1'b1);
    cycle(1'b1, 8'h33, 1'b1);
    chk("stream level<=1", 32'(level), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Fill to full, held fifth word accepted only the cycle after a pop
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    chk("full s_ready", 32'(s_ready), 32'd0);
    cycle(1'b1, 8'hA4, 1'b0);
    chk("full hold", 32'(last_push), 32'd0);
    cycle(1'b1, 8'hA4, 1'b1);
    chk("pop on full no push", 32'(last_push), 32'd0);
    chk("head after pop", 32'(o_data), 32'hA1);
    cycle(1'b1, 8'hA4, 1'b0);
    chk("a4 accepted", 32'(last_push), 32'd1);
    repeat (6) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous push/pop at level 2 across pointer wrap
    cycle(1'b1, 8'hC0, 1'b0);
    cycle(1'b1, 8'hC1, 1'b0);
    for (int i = 2; i < 12; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b1);
    chk("level steady 2", 32'(level), 32'd2);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-stream at level 3 discards buffered words
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0);
    chk("pre-reset level", 32'(level), 32'd3);
    apply_reset();
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hB0, 1'b0);
    chk("post-reset head", 32'(o_data), 32'hB0);
    cycle(1'b1, 8'hB1, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);

`ifdef RV_RX_COUNT_EN
    // Counter wraps after 2^CW pushes
    apply_reset();
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b1);
    chk("rx_count wrap", 32'(rx_count), 32'd1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
`endif

    // Random traffic; master holds each word until accepted
    pend = 1'b0;
    w    = '0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        apply_reset();
        pend = 1'b0;
      end
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        w    = 8'($urandom);
      end
      cycle(pend, pend ? w : 8'($urandom), $urandom_range(0, 9) < 4);
      if (last_push) pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
